// File: rtl/note_sequencer.sv
// note_sequencer: records the live key stream as {note, duration} events into
// the note buffer and plays them back to the tone generator, optionally looping.
module note_sequencer #(
    parameter int ADDR_W   = 8,
    parameter int NOTE_W   = 6,
    parameter int DUR_W    = 8,
    parameter int TICK_DIV = 50000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rec_start,
    input  logic                      play_start,
    input  logic                      stop,
    input  logic                      loop_en,
    input  logic [NOTE_W-1:0]         key_note,
    output logic                      buf_wr_en,
    output logic [ADDR_W-1:0]         buf_addr,
    output logic [NOTE_W+DUR_W-1:0]   buf_wdata,
    input  logic [NOTE_W+DUR_W-1:0]   buf_rdata,
    output logic [NOTE_W-1:0]         pb_note,
    output logic [1:0]                state,
    output logic [ADDR_W:0]           rec_len,
    output logic                      full
);
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
    localparam logic [DUR_W-1:0] DMAX = '1;
    localparam logic [ADDR_W:0] LAST = {1'b0, {ADDR_W{1'b1}}};

    typedef enum logic [1:0] {IDLE, REC, PLAY_RD, PLAY_HOLD} state_t;

    state_t st, st_n;
    logic [PW-1:0] presc, presc_n;
    logic [NOTE_W-1:0] cur_note, cur_n, pb_n;
    logic [DUR_W-1:0] dur, dur_n, hold, hold_n;
    logic [ADDR_W-1:0] rd_idx, rd_n, addr_n;
    logic [ADDR_W:0] rec_len_n;
    logic [NOTE_W+DUR_W-1:0] wdata_n;
    logic ph, ph_n, we_n, full_n, tick, playing;

    assign tick = presc == PMAX;
    assign playing = st == PLAY_RD || st == PLAY_HOLD;
    assign state = st;

    always_comb begin
        st_n = st;
        presc_n = tick ? '0 : presc + 1'b1;
        cur_n = cur_note;
        dur_n = dur;
        hold_n = hold;
        rd_n = rd_idx;
        ph_n = 1'b0;
        rec_len_n = rec_len;
        full_n = full;
        we_n = 1'b0;
        addr_n = buf_addr;
        wdata_n = buf_wdata;
        pb_n = pb_note;
        case (st)
            IDLE: if (play_start && rec_len != '0) begin
                st_n = PLAY_RD;
                rd_n = '0;
                addr_n = '0;
            end
            REC: begin
                if (tick) dur_n = dur + 1'b1;
                if (stop || key_note != cur_note || dur == DMAX) begin
                    cur_n = key_note;
                    dur_n = '0;
                    // zero-duration events are key bounce and are dropped
                    if (dur != '0) begin
                        we_n = 1'b1;
                        addr_n = rec_len[ADDR_W-1:0];
                        wdata_n = {cur_note, dur};
                        rec_len_n = rec_len + 1'b1;
                        full_n = rec_len == LAST;
                    end
                    if (stop || full_n) st_n = IDLE;
                end
            end
            PLAY_RD: if (!ph) ph_n = 1'b1;
            else begin
                pb_n = buf_rdata[NOTE_W+DUR_W-1:DUR_W];
                hold_n = buf_rdata[DUR_W-1:0];
                presc_n = '0;
                st_n = PLAY_HOLD;
            end
            default: if (tick) begin
                hold_n = hold - 1'b1;
                if (hold <= DUR_W'(1)) begin
                    if ({1'b0, rd_idx} + 1'b1 < rec_len) begin
                        rd_n = rd_idx + 1'b1;
                        addr_n = rd_idx + 1'b1;
                        st_n = PLAY_RD;
                    end else if (loop_en) begin
                        rd_n = '0;
                        addr_n = '0;
                        st_n = PLAY_RD;
                    end else begin
                        pb_n = '0;
                        st_n = IDLE;
                    end
                end
            end
        endcase
        if (playing && stop) begin
            st_n = IDLE;
            pb_n = '0;
        end else if (playing && play_start && !rec_start) begin
            st_n = PLAY_RD;
            rd_n = '0;
            addr_n = '0;
            ph_n = 1'b0;
        end
        if (rec_start && !stop) begin
            st_n = REC;
            cur_n = key_note;
            dur_n = '0;
            presc_n = '0;
            rec_len_n = '0;
            full_n = 1'b0;
            pb_n = '0;
            we_n = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= IDLE;
            presc <= '0;
            cur_note <= '0;
            dur <= '0;
            hold <= '0;
            rd_idx <= '0;
            ph <= 1'b0;
            rec_len <= '0;
            full <= 1'b0;
            buf_wr_en <= 1'b0;
            buf_addr <= '0;
            buf_wdata <= '0;
            pb_note <= '0;
        end else begin
            st <= st_n;
            presc <= presc_n;
            cur_note <= cur_n;
            dur <= dur_n;
            hold <= hold_n;
            rd_idx <= rd_n;
            ph <= ph_n;
            rec_len <= rec_len_n;
            full <= full_n;
            buf_wr_en <= we_n;
            buf_addr <= addr_n;
            buf_wdata <= wdata_n;
            pb_note <= pb_n;
        end
    end
endmodule

// File: doc/note_sequencer.md
# note_sequencer

Record/playback controller for the piano's note buffer memory. In RECORD it timestamps the live key stream into {note, duration} events and writes them to the buffer. In PLAY it reads events back and drives `pb_note` for each event's duration, optionally looping. It sits between the key decoder and the tone generator and owns every buffer address and write enable.

## Interface
- `ADDR_W`, 8: buffer address width; capacity is 2^ADDR_W events.
- `NOTE_W`, 6: note code width; code 0 means rest/no key.
- `DUR_W`, 8: duration field width, in ticks.
- `TICK_DIV`, 50000: clk cycles per duration tick (1 ms at 50 MHz).
- `clk`  in  1: system clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `rec_start`  in  1: one-cycle pulse, begin recording (debounced upstream).
- `play_start`  in  1: one-cycle pulse, begin playback.
- `stop`  in  1: one-cycle pulse, end recording or playback.
- `loop_en`  in  1: level; when 1, playback wraps to event 0 after the last event.
- `key_note`  in  NOTE_W: live key code, synchronous to clk.
- `buf_wr_en`  out  1: buffer write strobe.
- `buf_addr`  out  ADDR_W: buffer address for both read and write.
- `buf_wdata`  out  NOTE_W+DUR_W: event write data, {note, dur}.
- `buf_rdata`  in  NOTE_W+DUR_W: event read data, valid one clk after `buf_addr` (synchronous RAM).
- `pb_note`  out  NOTE_W: playback note to the tone generator.
- `state`  out  2: 0 IDLE, 1 REC, 2 PLAY_RD, 3 PLAY_HOLD.
- `rec_len`  out  ADDR_W+1: number of valid events in the buffer.
- `full`  out  1: the last recording stopped because the buffer filled.

## Operation
- All outputs are registered. Reset values are 0 for `buf_wr_en`, `buf_addr`, `buf_wdata`, `pb_note`, `state`, `rec_len` and `full`. Reset also clears the prescaler and all counters.
- **Prescaler:** counts 0..TICK_DIV-1 and pulses `tick` at TICK_DIV-1. It is cleared on entry to REC and on every event load in PLAY.
- **Command priority (same cycle):** `stop` > `rec_start` > `play_start`.
- **IDLE:**
  - `rec_start` goes to REC with `wr_idx`=0, `rec_len`=0, `full`=0, `cur_note`=`key_note`, `dur`=0.
  - `play_start` goes to PLAY_RD with `rd_idx`=0 if `rec_len`>0. Otherwise it is ignored.
- **REC:**
  - `dur` increments on `tick`.
  - An event is written when any of these occurs:
    - `key_note` != `cur_note`;
    - `dur` reaches 2^DUR_W-1;
    - `stop` is asserted.
  - Write action: if `dur`>0, write {`cur_note`, `dur`} at `wr_idx`, then increment `wr_idx` and `rec_len`. If `dur`==0, the event is discarded as a glitch filter.
  - After any write or discard, `cur_note`=`key_note` and `dur`=0. On saturation the same note continues as a new event.
  - Rests are recorded as note 0.
  - `rec_start` in REC restarts the recording from address 0. `play_start` is ignored.
  - When a write makes `rec_len`==2^ADDR_W: set `full`=1 and go to IDLE.
  - `stop`: flush the event per the write rule above, then go to IDLE.
- **PLAY_RD:** lasts exactly 2 cycles.
  - Cycle 1 drives `buf_addr`=`rd_idx`.
  - Cycle 2 captures `buf_rdata`: `pb_note`=note, `hold`=dur. The prescaler clears and the block goes to PLAY_HOLD.
- **PLAY_HOLD:**
  - `hold` decrements on `tick`.
  - When it reaches 0 and `rd_idx`<`rec_len`-1: `rd_idx`++ and go to PLAY_RD.
  - When it reaches 0 on the last event:
    - with `loop_en`=1, set `rd_idx`=0 and go to PLAY_RD;
    - otherwise set `pb_note`=0 and go to IDLE.
- **Commands while playing:**
  - `stop` in either PLAY state goes to IDLE with `pb_note`=0.
  - `play_start` restarts at `rd_idx`=0.
  - `rec_start` aborts playback (`pb_note`=0) and enters REC.
- `buf_wr_en` is asserted only in REC. `pb_note` stays 0 outside the PLAY states, except that its value is held through PLAY_RD between events.
- `rec_len` and buffer contents survive `stop`. Only `rec_start` or reset clears `rec_len`.

## Timing
- Write latency: a triggering condition sampled at edge N gives `buf_wr_en`=1 for exactly one cycle after edge N, with `buf_addr`=old `wr_idx`.
- Command latency: `state` changes on the edge that samples the command pulse.
- Event playback: `pb_note` is valid 2 cycles after PLAY_RD entry and held for dur×TICK_DIV cycles. Inter-event overhead is 2 cycles, during which the previous note is held.
- `rst_n` low asynchronously forces all state to reset values mid-record or mid-play. No write strobe is issued during or after reset assertion.
- `rec_len` is updated on the same edge as `buf_wr_en` rises.

## Test plan
Run with TICK_DIV=4.
- **Reset:** assert `rst_n`=0 mid-PLAY_HOLD with `pb_note`=12 -> all outputs are 0 immediately; `state`=0 after release.
- **Record/play:** `rec_start`, `key_note`=5 for 12 cycles, 9 for 8 cycles, 0, then `stop` -> writes {5,3}@0, {9,2}@1 and the rest event; `rec_len`=3. Then `play_start`, `loop_en`=0 -> `pb_note`=5 for 12 cycles, 9 for 8 cycles, 0, then IDLE.
- **Glitch/saturation:** a `key_note` blip lasting 2 cycles (< 1 tick) -> no write. Holding note 7 for 256 ticks -> writes {7,255}@0, then continues with a new event.
- **Full:** ADDR_W=3, 8 distinct notes of 1 tick each -> `rec_len`=8, `full`=1, `state`=IDLE with no `stop` needed.
- **Loop/priority:** `loop_en`=1 with 2 events -> `buf_addr` sequence 0,1,0,1…. `stop` and `rec_start` in the same cycle -> IDLE. `play_start` with `rec_len`=0 -> stays IDLE.
- **Abort:** `rec_start` during PLAY_HOLD -> `pb_note`=0, `state`=1, `rec_len`=0 on the next edge.
